// File: rtl/alu_pkg.sv
// Shared types for the tinyalu arbiter: ALU opcodes, result word and arbiter FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_NOP, OP_ADD, OP_AND, OP_XOR, OP_MUL, OP_SUB, OP_NOT, OP_INC
  } operation_t;

  typedef logic [15:0] result_t;

  typedef enum logic [2:0] {
    IDLE, ISSUE, RESP, ABORT, GAP
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Start/done bus between the arbiter (master) and the shared tinyalu (slave).
interface alu_arbiter_if;

  logic                alu_start;
  logic [7:0]          alu_A;
  logic [7:0]          alu_B;
  alu_pkg::operation_t alu_op;
  logic                alu_done;
  alu_pkg::result_t    alu_result;

  modport master (output alu_start, alu_A, alu_B, alu_op, input alu_done, alu_result);
  modport slave  (input alu_start, alu_A, alu_B, alu_op, output alu_done, alu_result);

endinterface

// File: rtl/alu_rr_pick.sv
// Round-robin pick: first set request at or after ptr (wrapping) as one-hot grant and index.
module alu_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W:0]   sum;

  // Rotate so ptr sits at bit 0; the lowest set bit of rot is the winner.
  always_comb begin
    rot = N_REQ'({req, req} >> ptr);
    sum = '0;
    any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (IDX_W+1)'(k);
      end
    end
    if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
    idx   = sum[IDX_W-1:0];
    grant = any ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one start/done tinyalu between N_REQ requesters, round-robin, one op at a time,
// routing each result (or a timeout error) back to the issuing requester.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*8-1:0] req_A,
  input  logic [N_REQ*8-1:0] req_B,
  input  logic [N_REQ*3-1:0] req_op,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   rsp_valid,
  output result_t            rsp_result,
  output logic               rsp_error,
  alu_arbiter_if.master      alu
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [7:0]       a_q, a_d, b_q, b_d;
  operation_t       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  result_t          res_q, res_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [7:0]       sel_a, sel_b;
  operation_t       sel_op;

  alu_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = OP_NOP;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_a  = req_A[8*i +: 8];
        sel_b  = req_B[8*i +: 8];
        sel_op = operation_t'(req_op[3*i +: 3]);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_gnt;
          a_d     = sel_a;
          b_d     = sel_b;
          op_d    = sel_op;
          cnt_d   = '0;
          ptr_d   = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        // done beats a timeout landing on the same cycle
        if (alu.alu_done) begin
          res_d   = alu.alu_result;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ABORT;
        end
      end
      RESP, ABORT: state_d = GAP;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Outputs decode from registered state, so a reset edge clears them all at once.
  assign alu.alu_start = (state_q == ISSUE);
  assign alu.alu_A     = a_q;
  assign alu.alu_B     = b_q;
  assign alu.alu_op    = op_q;
  assign req_ack       = (state_q == ISSUE && cnt_q == '0) ? gnt_q : '0;
  assign rsp_valid     = (state_q == RESP || state_q == ABORT) ? gnt_q : '0;
  assign rsp_error     = (state_q == ABORT);
  assign rsp_result    = (state_q == RESP) ? res_q : '0;

endmodule
